operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- ID/EX stage of the pipelined core. It drives the register-file read addresses and selects each operand from the register file, the EX result or the WB result (forwarding).
- It detects load-use hazards and inserts one bubble per hazard, then registers the decoded instruction and operands into the ID/EX pipeline register.
- Upstream is the decode stage; downstream is the ALU/EX stage. The WB port of the register file is fed from the same write-back bus this block snoops.

Parameters:
- REG_ADDRESS_SIZE, 3, register address width.
- REG_DATA_WIDTH, 8, datapath width.
- OP_WIDTH, 4, opcode field width.
- PERF_WIDTH, 8, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_op  in  OP_WIDTH  opcode
- in_ra, in_rb, in_rd  in  REG_ADDRESS_SIZE  source A, source B, destination
- in_wr  in  1  instruction writes rd
- in_use_imm  in  1  operand B is the immediate
- in_imm  in  REG_DATA_WIDTH  immediate
- rf_aa, rf_ba  out  REG_ADDRESS_SIZE  register-file read addresses
- rf_data_a, rf_data_b  in  REG_DATA_WIDTH  register-file read data
- ex_wr, ex_is_load  in  1  EX-stage instruction writes rd / is a load
- ex_rd  in  REG_ADDRESS_SIZE  EX destination
- ex_result  in  REG_DATA_WIDTH  EX ALU result
- wb_wr  in  1  write-back enable
- wb_rd  in  REG_ADDRESS_SIZE  write-back destination
- wb_data  in  REG_DATA_WIDTH  write-back data
- flush  in  1  squash the younger instruction (branch taken)
- out_ready  in  1  EX can accept
- out_valid, out_wr  out  1  ID/EX valid, writes rd
- out_op  out  OP_WIDTH  registered opcode
- out_rd  out  REG_ADDRESS_SIZE  registered destination
- out_a, out_b  out  REG_DATA_WIDTH  registered operands
- stall_count  out  PERF_WIDTH  saturating count of hazard-bubble cycles

Behaviour:
- Reset is rst: synchronous, active-low. Clock is clk.
- rst=0 at a posedge clears every registered output (out_valid, out_wr, out_op, out_rd, out_a, out_b, stall_count) to 0. Reset has priority over every other input.
- rf_aa=in_ra and rf_ba=in_rb, combinational and unconditional.
- Operand A select, first match wins:
  - in_ra==0 → 0.
  - ex_wr && !ex_is_load && ex_rd==in_ra → ex_result.
  - wb_wr && wb_rd==in_ra → wb_data.
  - otherwise rf_data_a.
- Operand B: same priority using in_rb. in_use_imm=1 overrides to in_imm, and no hazard check is made on rb.
- R0 is never forwarded, even if ex_rd or wb_rd is 0.
- Hazard: hz = in_valid && ex_wr && ex_is_load && ex_rd!=0 && (ex_rd==in_ra || (!in_use_imm && ex_rd==in_rb)).
- in_ready = out_ready && !hz. It is combinational.
- Pipeline register update at each posedge, in priority order:
  1. rst=0 → clear.
  2. flush=1 → out_valid←0 and out_wr←0; the other fields are don't-care. An instruction presented the same cycle is squashed, and in_ready still reads as computed.
  3. out_ready=0 → hold all outputs unchanged.
  4. hz=1 → bubble (out_valid←0, out_wr←0) and stall_count←sat(stall_count+1). Decode must hold its inputs. The hazard clears on the next cycle as the load moves to WB, and WB forwarding supplies the data.
  5. in_valid=1 → capture op/rd/wr and the selected operands; out_valid←1.
  6. otherwise out_valid←0.
- stall_count saturates at all-ones and does not wrap. flush and out_ready=0 do not increment it.
- Latency: one cycle from acceptance to out_valid, plus one cycle per load-use hazard.
- Back-to-back accepts are allowed every cycle (full throughput).

Decomposition:
- Shared package cpu_pkg holds REG_ADDRESS_SIZE, REG_DATA_WIDTH and OP_WIDTH as constants, plus the opcode localparams.
- One sub-module, operand_forward_mux, holds the per-operand priority select. It is instantiated twice.

Test Plan:
- Plain read: R3=0x5A in the register file, no writers active, issue op with ra=3, rb=0 → next cycle out_a=0x5A, out_b=0x00, out_valid=1.
- EX-over-WB priority: ex_rd=2 with result 0x11 (non-load), wb_rd=2 with data 0x22, ra=2 → out_a=0x11. With ex_wr=0 → out_a=0x22.
- Load-use: ex_is_load, ex_rd=4, in_rb=4, in_use_imm=0 → in_ready=0, one bubble, stall_count=1. Next cycle the load is in WB with wb_data=0x7E → out_b=0x7E, out_valid=1.
- Immediate bypasses the hazard: same as above but in_use_imm=1, in_imm=0x09 → no stall, out_b=0x09.
- Flush, backpressure, reset:
  - flush=1 with a valid instruction → out_valid=0.
  - out_ready=0 for 3 cycles → outputs held.
  - rst=0 mid-stream → all outputs 0 on the next cycle.
- Saturation and R0: force 260 hazard cycles → stall_count=0xFF. Separately, ex_rd=0 with ex_result=0x33 and ra=0 → out_a=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath widths and opcode encodings for the pipelined core.
package cpu_pkg;

  localparam int REG_ADDRESS_SIZE = 3;
  localparam int REG_DATA_WIDTH   = 8;
  localparam int OP_WIDTH         = 4;

  // Opcode encodings carried through the ID/EX register.
  localparam logic [OP_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'h3;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'h4;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_WIDTH-1:0] OP_LOAD = 4'h6;
  localparam logic [OP_WIDTH-1:0] OP_STOR = 4'h7;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand source select: R0, EX forward, WB forward, register file,
// with an optional immediate override. First match wins.
module operand_forward_mux
  import cpu_pkg::*;
#(
  parameter int AW = REG_ADDRESS_SIZE,
  parameter int DW = REG_DATA_WIDTH
) (
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_rf_data,
  input  logic          i_ex_wr,
  input  logic          i_ex_is_load,
  input  logic [AW-1:0] i_ex_rd,
  input  logic [DW-1:0] i_ex_result,
  input  logic          i_wb_wr,
  input  logic [AW-1:0] i_wb_rd,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_use_imm,
  input  logic [DW-1:0] i_imm,
  output logic [DW-1:0] o_data
);

  // A load's data is not ready in EX, so only ALU results forward from EX.
  // R0 reads as zero regardless of any writer targeting it.
  always_comb begin
    o_data = i_rf_data;
    if (i_use_imm)
      o_data = i_imm;
    else if (i_addr == '0)
      o_data = '0;
    else if (i_ex_wr && !i_ex_is_load && (i_ex_rd == i_addr))
      o_data = i_ex_result;
    else if (i_wb_wr && (i_wb_rd == i_addr))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: register-file addressing, operand forwarding, load-use
// bubble insertion and the ID/EX pipeline register.
//
// Handshake: an instruction transfers from decode when in_valid && in_ready.
// in_ready is combinational (out_ready && no load-use hazard); decode must
// hold its inputs stable while in_valid && !in_ready. out_valid marks a
// live ID/EX entry; outputs are held while out_ready is low.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int PERF_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_WIDTH-1:0]         in_op,
  input  logic [REG_ADDRESS_SIZE-1:0] in_ra,
  input  logic [REG_ADDRESS_SIZE-1:0] in_rb,
  input  logic [REG_ADDRESS_SIZE-1:0] in_rd,
  input  logic                        in_wr,
  input  logic                        in_use_imm,
  input  logic [REG_DATA_WIDTH-1:0]   in_imm,
  output logic [REG_ADDRESS_SIZE-1:0] rf_aa,
  output logic [REG_ADDRESS_SIZE-1:0] rf_ba,
  input  logic [REG_DATA_WIDTH-1:0]   rf_data_a,
  input  logic [REG_DATA_WIDTH-1:0]   rf_data_b,
  input  logic                        ex_wr,
  input  logic                        ex_is_load,
  input  logic [REG_ADDRESS_SIZE-1:0] ex_rd,
  input  logic [REG_DATA_WIDTH-1:0]   ex_result,
  input  logic                        wb_wr,
  input  logic [REG_ADDRESS_SIZE-1:0] wb_rd,
  input  logic [REG_DATA_WIDTH-1:0]   wb_data,
  input  logic                        flush,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic                        out_wr,
  output logic [OP_WIDTH-1:0]         out_op,
  output logic [REG_ADDRESS_SIZE-1:0] out_rd,
  output logic [REG_DATA_WIDTH-1:0]   out_a,
  output logic [REG_DATA_WIDTH-1:0]   out_b,
  output logic [PERF_WIDTH-1:0]       stall_count
);

  logic [REG_DATA_WIDTH-1:0] w_opnd_a;
  logic [REG_DATA_WIDTH-1:0] w_opnd_b;
  logic                      w_hz;

  logic                        r_valid;
  logic                        r_wr;
  logic [OP_WIDTH-1:0]         r_op;
  logic [REG_ADDRESS_SIZE-1:0] r_rd;
  logic [REG_DATA_WIDTH-1:0]   r_a;
  logic [REG_DATA_WIDTH-1:0]   r_b;
  logic [PERF_WIDTH-1:0]       r_stall_count;

  assign rf_aa = in_ra;
  assign rf_ba = in_rb;

  operand_forward_mux u_mux_a (
    .i_addr       (in_ra),
    .i_rf_data    (rf_data_a),
    .i_ex_wr      (ex_wr),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_wb_wr      (wb_wr),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .i_use_imm    (1'b0),
    .i_imm        ('0),
    .o_data       (w_opnd_a)
  );

  operand_forward_mux u_mux_b (
    .i_addr       (in_rb),
    .i_rf_data    (rf_data_b),
    .i_ex_wr      (ex_wr),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_wb_wr      (wb_wr),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .i_use_imm    (in_use_imm),
    .i_imm        (in_imm),
    .o_data       (w_opnd_b)
  );

  // Load-use hazard: a load in EX targets a register this instruction reads.
  // rb is ignored when the immediate replaces it.
  always_comb begin
    w_hz = in_valid && ex_wr && ex_is_load && (ex_rd != '0) &&
           ((ex_rd == in_ra) || (!in_use_imm && (ex_rd == in_rb)));
  end

  assign in_ready = out_ready && !w_hz;

  // ID/EX register: reset, flush, backpressure hold, bubble, capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_wr          <= 1'b0;
      r_op          <= '0;
      r_rd          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
    end else if (!out_ready) begin
      r_valid <= r_valid;
    end else if (w_hz) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      if (!(&r_stall_count))
        r_stall_count <= r_stall_count + 1'b1;
    end else if (in_valid) begin
      r_valid <= 1'b1;
      r_wr    <= in_wr;
      r_op    <= in_op;
      r_rd    <= in_rd;
      r_a     <= w_opnd_a;
      r_b     <= w_opnd_b;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_wr      = r_wr;
  assign out_op      = r_op;
  assign out_rd      = r_rd;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding priority, load-use
// bubbles, immediate bypass, flush, backpressure, reset and saturation.
module tb_operand_fetch_stage;
  import cpu_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [OP_WIDTH-1:0]         in_op;
  logic [REG_ADDRESS_SIZE-1:0] in_ra;
  logic [REG_ADDRESS_SIZE-1:0] in_rb;
  logic [REG_ADDRESS_SIZE-1:0] in_rd;
  logic                        in_wr;
  logic                        in_use_imm;
  logic [REG_DATA_WIDTH-1:0]   in_imm;
  logic [REG_ADDRESS_SIZE-1:0] rf_aa;
  logic [REG_ADDRESS_SIZE-1:0] rf_ba;
  logic [REG_DATA_WIDTH-1:0]   rf_data_a;
  logic [REG_DATA_WIDTH-1:0]   rf_data_b;
  logic                        ex_wr;
  logic                        ex_is_load;
  logic [REG_ADDRESS_SIZE-1:0] ex_rd;
  logic [REG_DATA_WIDTH-1:0]   ex_result;
  logic                        wb_wr;
  logic [REG_ADDRESS_SIZE-1:0] wb_rd;
  logic [REG_DATA_WIDTH-1:0]   wb_data;
  logic                        flush;
  logic                        out_ready;
  logic                        out_valid;
  logic                        out_wr;
  logic [OP_WIDTH-1:0]         out_op;
  logic [REG_ADDRESS_SIZE-1:0] out_rd;
  logic [REG_DATA_WIDTH-1:0]   out_a;
  logic [REG_DATA_WIDTH-1:0]   out_b;
  logic [7:0]                  stall_count;

  int n_checks;
  int n_errors;

  operand_fetch_stage #(.PERF_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_ra       (in_ra),
    .in_rb       (in_rb),
    .in_rd       (in_rd),
    .in_wr       (in_wr),
    .in_use_imm  (in_use_imm),
    .in_imm      (in_imm),
    .rf_aa       (rf_aa),
    .rf_ba       (rf_ba),
    .rf_data_a   (rf_data_a),
    .rf_data_b   (rf_data_b),
    .ex_wr       (ex_wr),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .wb_wr       (wb_wr),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_wr      (out_wr),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_a       (out_a),
    .out_b       (out_b),
    .stall_count (stall_count)
  );

  // Clock and global timeout.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_op      = '0;
    in_ra      = '0;
    in_rb      = '0;
    in_rd      = '0;
    in_wr      = 1'b0;
    in_use_imm = 1'b0;
    in_imm     = '0;
    rf_data_a  = '0;
    rf_data_b  = '0;
    ex_wr      = 1'b0;
    ex_is_load = 1'b0;
    ex_rd      = '0;
    ex_result  = '0;
    wb_wr      = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".wr"},    {31'd0, out_wr},    32'd0);
    check({tag, ".op"},    {28'd0, out_op},    32'd0);
    check({tag, ".rd"},    {29'd0, out_rd},    32'd0);
    check({tag, ".a"},     {24'd0, out_a},     32'd0);
    check({tag, ".b"},     {24'd0, out_b},     32'd0);
    check({tag, ".stall"}, {24'd0, stall_count}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();

    // Reset state.
    check_all_zero("reset");

    // Plain read with rb=R0: R3 from register file, operand B forced to 0.
    rst = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_ra = 3'd3; in_rb = 3'd0; in_rd = 3'd5; in_wr = 1'b1;
    rf_data_a = 8'h5A; rf_data_b = 8'h77;
    settle();
    check("plain.rf_aa", {29'd0, rf_aa}, 32'd3);
    check("plain.rf_ba", {29'd0, rf_ba}, 32'd0);
    check("plain.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("plain.valid", {31'd0, out_valid}, 32'd1);
    check("plain.a", {24'd0, out_a}, 32'h5A);
    check("plain.b", {24'd0, out_b}, 32'h00);
    check("plain.op", {28'd0, out_op}, 32'd1);
    check("plain.rd", {29'd0, out_rd}, 32'd5);
    check("plain.wr", {31'd0, out_wr}, 32'd1);

    // EX forward beats WB forward; WB forward when EX idle.
    in_op = OP_SUB; in_ra = 3'd2; in_rb = 3'd1; in_rd = 3'd6; in_wr = 1'b0;
    rf_data_a = 8'h44; rf_data_b = 8'h10;
    ex_wr = 1'b1; ex_rd = 3'd2; ex_result = 8'h11;
    wb_wr = 1'b1; wb_rd = 3'd2; wb_data = 8'h22;
    tick();
    check("exfwd.a", {24'd0, out_a}, 32'h11);
    check("exfwd.b", {24'd0, out_b}, 32'h10);
    check("exfwd.wr", {31'd0, out_wr}, 32'd0);
    ex_wr = 1'b0;
    tick();
    check("wbfwd.a", {24'd0, out_a}, 32'h22);

    // Load-use on rb: one bubble, then WB forwarding supplies the value.
    idle_inputs();
    in_valid = 1'b1; in_op = OP_XOR; in_ra = 3'd1; in_rb = 3'd4; in_rd = 3'd7; in_wr = 1'b1;
    rf_data_a = 8'h01; rf_data_b = 8'hEE;
    ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd4; ex_result = 8'hAA;
    settle();
    check("lu.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lu.bubble_valid", {31'd0, out_valid}, 32'd0);
    check("lu.stall", {24'd0, stall_count}, 32'd1);
    ex_wr = 1'b0; ex_is_load = 1'b0;
    wb_wr = 1'b1; wb_rd = 3'd4; wb_data = 8'h7E;
    settle();
    check("lu2.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("lu2.valid", {31'd0, out_valid}, 32'd1);
    check("lu2.b", {24'd0, out_b}, 32'h7E);
    check("lu2.a", {24'd0, out_a}, 32'h01);
    check("lu2.stall", {24'd0, stall_count}, 32'd1);

    // Immediate replaces rb: no hazard even though load targets rb.
    idle_inputs();
    in_valid = 1'b1; in_op = OP_AND; in_ra = 3'd1; in_rb = 3'd4; in_rd = 3'd2; in_wr = 1'b1;
    in_use_imm = 1'b1; in_imm = 8'h09; rf_data_a = 8'h0F; rf_data_b = 8'hEE;
    ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd4;
    settle();
    check("imm.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("imm.valid", {31'd0, out_valid}, 32'd1);
    check("imm.b", {24'd0, out_b}, 32'h09);
    check("imm.stall", {24'd0, stall_count}, 32'd1);

    // Flush squashes a valid instruction.
    idle_inputs();
    in_valid = 1'b1; in_op = OP_OR; in_ra = 3'd3; in_rd = 3'd3; in_wr = 1'b1; rf_data_a = 8'h12;
    flush = 1'b1;
    settle();
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    check("flush.wr", {31'd0, out_wr}, 32'd0);

    // Backpressure: load an entry, then hold for 3 cycles despite new
    // inputs and a pending load-use hazard (which must not count).
    flush = 1'b0;
    in_op = OP_STOR; in_ra = 3'd3; in_rb = 3'd0; in_rd = 3'd4; in_wr = 1'b1; rf_data_a = 8'h3C;
    tick();
    check("bp.load_valid", {31'd0, out_valid}, 32'd1);
    check("bp.load_a", {24'd0, out_a}, 32'h3C);
    out_ready = 1'b0;
    in_op = OP_SUB; in_ra = 3'd5; in_rd = 3'd1; in_wr = 1'b0; rf_data_a = 8'h99;
    ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd5;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp.valid", {31'd0, out_valid}, 32'd1);
      check("bp.a", {24'd0, out_a}, 32'h3C);
      check("bp.op", {28'd0, out_op}, 32'd7);
      check("bp.rd", {29'd0, out_rd}, 32'd4);
      check("bp.wr", {31'd0, out_wr}, 32'd1);
      check("bp.stall", {24'd0, stall_count}, 32'd1);
    end

    // Reset mid-stream wins over a valid instruction.
    out_ready = 1'b1; ex_wr = 1'b0; ex_is_load = 1'b0;
    rst = 1'b0;
    tick();
    check_all_zero("midrst");
    rst = 1'b1;

    // R0 is never forwarded even when EX/WB target R0.
    idle_inputs();
    in_valid = 1'b1; in_op = OP_ADD; in_ra = 3'd0; in_rb = 3'd0; in_rd = 3'd1; in_wr = 1'b1;
    rf_data_a = 8'h55; rf_data_b = 8'h56;
    ex_wr = 1'b1; ex_rd = 3'd0; ex_result = 8'h33;
    wb_wr = 1'b1; wb_rd = 3'd0; wb_data = 8'h66;
    tick();
    check("r0.valid", {31'd0, out_valid}, 32'd1);
    check("r0.a", {24'd0, out_a}, 32'h00);
    check("r0.b", {24'd0, out_b}, 32'h00);

    // A load targeting R0 never stalls.
    ex_is_load = 1'b1;
    settle();
    check("r0load.in_ready", {31'd0, in_ready}, 32'd1);

    // No instruction presented: load in EX is not a hazard.
    idle_inputs();
    ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd2; in_ra = 3'd2;
    settle();
    check("novalid.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("novalid.valid", {31'd0, out_valid}, 32'd0);
    check("novalid.stall", {24'd0, stall_count}, 32'd0);

    // Saturation: 254 hazards -> 0xFE, 6 more -> held at 0xFF.
    in_valid = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("sat.fe", {24'd0, stall_count}, 32'hFE);
    for (int i = 0; i < 6; i++) tick();
    check("sat.ff", {24'd0, stall_count}, 32'hFF);
    check("sat.valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
